// File: rtl/shared_out_arb_pkg.sv
// ---------------------------------------------------------------------------
// shared_out_arb_pkg : state encoding and default sizing for shared_out_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shared_out_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ     = 6;
  localparam int DEF_HOLD_CYCLES = 4;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin selector starting the scan at ptr_i
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 6,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int j;

  // Scan backwards so the last hit written is the first one in round-robin order.
  always_comb begin
    idx_o = '0;
    j     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[j]) begin
        idx_o = IDX_W'(j);
      end
    end
  end

  assign any_o  = |req_i;
  assign pick_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

`default_nettype wire

// File: rtl/shared_out_arbiter.sv
// ---------------------------------------------------------------------------
// shared_out_arbiter : round-robin owner of one shared 1-bit net, registered out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shared_out_arbiter
  import shared_out_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0] grant,
  output logic               out,
  output logic               out_valid,
  output logic               busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;

  logic [IDX_W-1:0]   owner_inc;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               release_now;

  assign owner_inc   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  // In GRANT the picker already sees the post-release pointer, giving zero-bubble handover.
  assign pick_ptr    = (state_q == GRANT) ? owner_inc : rr_ptr_q;
  assign release_now = !req[owner_q] || (cnt_q == CNT_W'(HOLD_CYCLES));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i  (req),
    .ptr_i  (pick_ptr),
    .pick_o (pick_onehot),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    out_d       = (state_q == GRANT) && data_in[owner_q];
    out_valid_d = (state_q == GRANT);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          rr_ptr_d = owner_inc;
          if (pick_any) begin
            grant_d = pick_onehot;
            owner_d = pick_idx;
            cnt_d   = CNT_W'(1);
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign grant     = grant_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == GRANT);

endmodule

`default_nettype wire
